// File: rtl/module_data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// module_data_memory_ctrl
//
// Data-memory controller between the MEM pipeline stage and the data array.
// Accepts one request at a time over a req/ready handshake, inserts
// WAIT_STATES extra cycles, then completes the access with a one-cycle ack.
// Writes honour per-byte enables. After every reset the whole array is swept
// to zero (busy=1) before the first request is accepted. Word indices at or
// beyond MEMORY complete with addr_err=1 and never touch the array.
//
// Optional feature (macro DMEM_STATS_EN): adds saturating 16-bit counters of
// acked in-range reads (rd_count) and writes (wr_count), cleared only by rst_n.
//
// Ports:
//   clk       in   single clock, all state on posedge
//   rst_n     in   asynchronous active-low reset
//   req       in   request valid, sampled only while ready=1
//   wr_en     in   1=write, 0=read
//   addr      in   word index [ADDRESS_BITS]
//   be        in   byte enables for writes [WORD_SIZE/8]
//   data_in   in   write data [WORD_SIZE]
//   ready     out  controller accepts a request this cycle
//   ack       out  one-cycle completion pulse
//   data_out  out  read data, valid with ack, held until the next ack
//   addr_err  out  acked access was out of range
//   busy      out  post-reset clear sweep in progress
//   rd_count  out  (DMEM_STATS_EN) in-range reads completed
//   wr_count  out  (DMEM_STATS_EN) in-range writes completed
// ---------------------------------------------------------------------------
module module_data_memory_ctrl #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int MEMORY       = 1024,
  parameter int WAIT_STATES  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req,
  input  logic                      wr_en,
  input  logic [ADDRESS_BITS-1:0]   addr,
  input  logic [WORD_SIZE/8-1:0]    be,
  input  logic [WORD_SIZE-1:0]      data_in,
  output logic                      ready,
  output logic                      ack,
  output logic [WORD_SIZE-1:0]      data_out,
  output logic                      addr_err,
  output logic                      busy
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]               rd_count,
  output logic [15:0]               wr_count
`endif
);

  localparam int BE_W  = WORD_SIZE / 8;
  localparam int IDX_W = (MEMORY > 1) ? $clog2(MEMORY) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(MEMORY - 1);
  localparam logic [ADDRESS_BITS:0] MEM_WORDS = (ADDRESS_BITS + 1)'(MEMORY);
  // Counter reaches zero after WAIT_STATES cycles in WAIT.
  localparam logic [3:0]            WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Control state and registered outputs
  state_e                  state_q,    state_d;
  logic [IDX_W-1:0]        sweep_q,    sweep_d;
  logic [3:0]              wait_q,     wait_d;
  logic                    ready_q,    ready_d;
  logic                    ack_q,      ack_d;
  logic                    busy_q,     busy_d;
  logic                    addr_err_q, addr_err_d;
  logic [WORD_SIZE-1:0]    data_out_q, data_out_d;

  // Request captured at acceptance
  logic                    cap_wr_q,    cap_wr_d;
  logic [ADDRESS_BITS-1:0] cap_addr_q,  cap_addr_d;
  logic [BE_W-1:0]         cap_be_q,    cap_be_d;
  logic [WORD_SIZE-1:0]    cap_data_q,  cap_data_d;

`ifdef DMEM_STATS_EN
  logic [15:0]             rd_count_q, rd_count_d;
  logic [15:0]             wr_count_q, wr_count_d;
`endif

  // Operands of the access that completes this cycle
  logic                    do_access;
  logic                    acc_wr;
  logic [ADDRESS_BITS-1:0] acc_addr;
  logic [BE_W-1:0]         acc_be;
  logic [WORD_SIZE-1:0]    acc_data;
  logic                    acc_oor;
  logic [IDX_W-1:0]        acc_idx;

  // Array write port
  logic                    mem_we;
  logic [IDX_W-1:0]        mem_idx;
  logic [BE_W-1:0]         mem_wbe;
  logic [WORD_SIZE-1:0]    mem_wdata;

  logic [WORD_SIZE-1:0]    mem [MEMORY];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path can leave a signal unassigned and
    // infer a latch.
    state_d    = state_q;
    sweep_d    = sweep_q;
    wait_d     = wait_q;
    ready_d    = ready_q;
    ack_d      = 1'b0;
    busy_d     = busy_q;
    addr_err_d = addr_err_q;
    data_out_d = data_out_q;
    cap_wr_d   = cap_wr_q;
    cap_addr_d = cap_addr_q;
    cap_be_d   = cap_be_q;
    cap_data_d = cap_data_q;
`ifdef DMEM_STATS_EN
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
`endif
    do_access  = 1'b0;
    acc_wr     = cap_wr_q;
    acc_addr   = cap_addr_q;
    acc_be     = cap_be_q;
    acc_data   = cap_data_q;
    mem_we     = 1'b0;
    mem_idx    = sweep_q;
    mem_wbe    = '0;
    mem_wdata  = '0;

    unique case (state_q)
      ST_INIT: begin
        mem_we  = 1'b1;
        mem_wbe = '1;
        if (sweep_q == LAST_IDX) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end

      ST_IDLE: begin
        if (req) begin
          cap_wr_d   = wr_en;
          cap_addr_d = addr;
          cap_be_d   = be;
          cap_data_d = data_in;
          ready_d    = 1'b0;
          if (WAIT_STATES == 0) begin
            // No wait states: the access completes on the acceptance edge,
            // straight from the inputs being captured.
            do_access = 1'b1;
            acc_wr    = wr_en;
            acc_addr  = addr;
            acc_be    = be;
            acc_data  = data_in;
          end else begin
            state_d = ST_WAIT;
            wait_d  = WAIT_LOAD;
          end
        end
      end

      ST_WAIT: begin
        if (wait_q == 4'd0) begin
          do_access = 1'b1;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase

    // The access is performed on the edge that enters RESP, so data_out and
    // addr_err become valid together with ack.
    acc_oor = ({1'b0, acc_addr} >= MEM_WORDS);
    acc_idx = acc_addr[IDX_W-1:0];
    if (do_access) begin
      state_d    = ST_RESP;
      ack_d      = 1'b1;
      addr_err_d = acc_oor;
      if (acc_oor) begin
        if (!acc_wr) begin
          data_out_d = '0;
        end
      end else if (acc_wr) begin
        mem_we    = 1'b1;
        mem_idx   = acc_idx;
        mem_wbe   = acc_be;
        mem_wdata = acc_data;
`ifdef DMEM_STATS_EN
        if (wr_count_q != 16'hFFFF) begin
          wr_count_d = wr_count_q + 16'd1;
        end
`endif
      end else begin
        data_out_d = mem[acc_idx];
`ifdef DMEM_STATS_EN
        if (rd_count_q != 16'hFFFF) begin
          rd_count_d = rd_count_q + 16'd1;
        end
`endif
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential blocks use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    if (!rst_n) begin
      state_q    <= ST_INIT;
      sweep_q    <= '0;
      wait_q     <= 4'd0;
      ready_q    <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b1;
      addr_err_q <= 1'b0;
      data_out_q <= '0;
      cap_wr_q   <= 1'b0;
      cap_addr_q <= '0;
      cap_be_q   <= '0;
      cap_data_q <= '0;
`ifdef DMEM_STATS_EN
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      wait_q     <= wait_d;
      ready_q    <= ready_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      addr_err_q <= addr_err_d;
      data_out_q <= data_out_d;
      cap_wr_q   <= cap_wr_d;
      cap_addr_q <= cap_addr_d;
      cap_be_q   <= cap_be_d;
      cap_data_q <= cap_data_d;
`ifdef DMEM_STATS_EN
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Data array
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset branch so it maps onto plain RAM; the INIT
  // sweep is what zeroes it after reset. While rst_n is low the FSM sits in
  // INIT with sweep_q=0, so the only write possible is a zero to word 0.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_wbe[i]) begin
          mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign ready    = ready_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign addr_err = addr_err_q;
  assign data_out = data_out_q;
`ifdef DMEM_STATS_EN
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_module_data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for module_data_memory_ctrl (MEMORY=16, WAIT_STATES=3).
// A word-array reference model with byte-merge arithmetic predicts every
// completed access; stimulus mixes directed cases with $urandom traffic.
// Inputs are scrambled while an access is in flight to show that only the
// captured request matters. Define DMEM_STATS_EN to also check the counters.
// ---------------------------------------------------------------------------
module tb_module_data_memory_ctrl;

  localparam int WS  = 3;
  localparam int MEM = 16;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        wr_en;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] data_in;
  logic        ready;
  logic        ack;
  logic [31:0] data_out;
  logic        addr_err;
  logic        busy;
`ifdef DMEM_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  module_data_memory_ctrl #(
    .WORD_SIZE    (32),
    .ADDRESS_BITS (32),
    .MEMORY       (MEM),
    .WAIT_STATES  (WS)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .wr_en    (wr_en),
    .addr     (addr),
    .be       (be),
    .data_in  (data_in),
    .ready    (ready),
    .ack      (ack),
    .data_out (data_out),
    .addr_err (addr_err),
    .busy     (busy)
`ifdef DMEM_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  // Reference model
  logic [31:0] model_mem [MEM];
  logic [31:0] exp_dout;
  int          rd_m;
  int          wr_m;

  int checks;
  int errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (got running, need finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Assert reset (from a negedge or mid-cycle), check reset outputs, release
  // it at a negedge and follow the clear sweep until ready rises.
  task automatic do_reset();
    int ack_seen;
    int init_bad;
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_dout", data_out, 32'd0);
    check("rst_err", 32'(addr_err), 32'd0);
    ack_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack !== 1'b0) ack_seen++;
    end
    check("rst_no_ack", 32'(ack_seen), 32'd0);
    for (int i = 0; i < MEM; i++) model_mem[i] = '0;
    exp_dout = '0;
    rd_m = 0;
    wr_m = 0;
    rst_n = 1'b1;
    init_bad = 0;
    for (int k = 1; k <= MEM; k++) begin
      @(negedge clk);
      if (k < MEM && (busy !== 1'b1 || ready !== 1'b0)) init_bad++;
    end
    check("init_hold", 32'(init_bad), 32'd0);
    check("init_ready", 32'(ready), 32'd1);
    check("init_busy", 32'(busy), 32'd0);
  endtask

  // One complete access with in-flight input scrambling.
  task automatic xact(input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input string tag);
    int   lat;
    int   rdy_bad;
    logic exp_err;
    @(negedge clk);
    for (int k = 0; k < 50 && ready !== 1'b1; k++) @(negedge clk);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    req = 1'b1; wr_en = w; addr = a; be = b; data_in = d;

    exp_err = (a >= 32'(MEM));
    if (!exp_err) begin
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) model_mem[a[3:0]][8*i +: 8] = d[8*i +: 8];
        wr_m++;
      end else begin
        exp_dout = model_mem[a[3:0]];
        rd_m++;
      end
    end else if (!w) begin
      exp_dout = '0;
    end

    lat = 0;
    rdy_bad = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ready !== 1'b0) rdy_bad++;
      if (ack === 1'b1) lat = n;
      // Anything driven now is either ignored (ready=0) or too late to matter.
      req     = 1'($urandom_range(0, 1));
      wr_en   = 1'($urandom_range(0, 1));
      addr    = $urandom;
      be      = 4'($urandom);
      data_in = $urandom;
      if (lat != 0) break;
    end
    check({tag, "_latency"}, 32'(lat), 32'(WS + 1));
    check({tag, "_busy_ready"}, 32'(rdy_bad), 32'd0);
    check({tag, "_dout"}, data_out, exp_dout);
    check({tag, "_err"}, 32'(addr_err), 32'(exp_err));
    @(negedge clk);
    req = 1'b0;
    check({tag, "_ready_after"}, 32'(ready), 32'd1);
    check({tag, "_ack_pulse"}, 32'(ack), 32'd0);
    check({tag, "_dout_hold"}, data_out, exp_dout);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b1;
    req     = 1'b0;
    wr_en   = 1'b0;
    addr    = '0;
    be      = '0;
    data_in = '0;
    #2;
    do_reset();

    // Cleared array reads back as zero.
    for (int i = 0; i < MEM; i++) xact(1'b0, 32'(i), 4'h0, 32'h0, "clr_rd");

    // Byte-enable merge.
    xact(1'b1, 32'd5, 4'hF, 32'hDEADBEEF, "wr_full");
    xact(1'b1, 32'd5, 4'b0011, 32'h00001234, "wr_half");
    xact(1'b0, 32'd5, 4'h0, 32'h0, "rd_merge");
    check("merge_value", data_out, 32'hDEAD1234);
    xact(1'b1, 32'd5, 4'h0, 32'hFFFFFFFF, "wr_none");
    xact(1'b0, 32'd5, 4'hF, 32'h0, "rd_none");

    // Out of range: first boundary word, a dropped write, a far index.
    xact(1'b0, 32'd15, 4'h0, 32'h0, "rd_last");
    xact(1'b0, 32'd16, 4'h0, 32'h0, "rd_oor16");
    xact(1'b1, 32'd20, 4'hF, 32'hCAFEF00D, "wr_oor20");
    xact(1'b0, 32'hFFFFFFFF, 4'h0, 32'h0, "rd_oor_max");
    for (int i = 0; i < MEM; i++) xact(1'b0, 32'(i), 4'h0, 32'h0, "oor_scan");

    // Reset in the middle of a write's wait states.
    xact(1'b1, 32'd2, 4'hF, 32'h11111111, "pre_wr2");
    @(negedge clk);
    for (int k = 0; k < 50 && ready !== 1'b1; k++) @(negedge clk);
    req = 1'b1; wr_en = 1'b1; addr = 32'd2; be = 4'hF; data_in = 32'h55;
    @(negedge clk);
    req = 1'b0;
    check("midwait_state", 32'(ready), 32'd0);
    do_reset();
    xact(1'b0, 32'd2, 4'h0, 32'h0, "rd_after_abort");

`ifdef DMEM_STATS_EN
    check("stats_after_rst_rd", 32'(rd_count), 32'd1);
    check("stats_after_rst_wr", 32'(wr_count), 32'd0);
`endif
    xact(1'b1, 32'd1, 4'hF, 32'hA5A5A5A5, "st_wr1");
    xact(1'b1, 32'd7, 4'h3, 32'h0BADF00D, "st_wr2");
    xact(1'b1, 32'd9, 4'h8, 32'h77000000, "st_wr3");
    xact(1'b0, 32'd7, 4'h0, 32'h0, "st_rd1");
    xact(1'b0, 32'd9, 4'h0, 32'h0, "st_rd2");
    xact(1'b0, 32'd40, 4'h0, 32'h0, "st_rd_oor");
`ifdef DMEM_STATS_EN
    check("stats_rd", 32'(rd_count), 32'(rd_m));
    check("stats_wr", 32'(wr_count), 32'(wr_m));
`endif

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      case ($urandom_range(0, 7))
        0:       a = $urandom;
        1:       a = 32'(MEM) + 32'($urandom_range(0, 15));
        default: a = 32'($urandom_range(0, MEM - 1));
      endcase
      xact(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, "rand");
    end
    for (int i = 0; i < MEM; i++) xact(1'b0, 32'(i), 4'h0, 32'h0, "final_scan");

`ifdef DMEM_STATS_EN
    check("stats_rd_final", 32'(rd_count), 32'(rd_m));
    check("stats_wr_final", 32'(wr_count), 32'(wr_m));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/module_data_memory_ctrl.md
Name: module_data_memory_ctrl

Overview:
Parametrised successor to the single-cycle data memory. It adds byte-enable writes and a req/ready/ack handshake with configurable wait states. After reset it sweeps the whole array to zero, and it flags out-of-range addresses. It sits between the MEM pipeline stage and the data array; the stage stalls on ready/ack.

Parameters:
WORD_SIZE, 32, data width in bits; must be a multiple of 8
ADDRESS_BITS, 32, address width; addresses are word indices
MEMORY, 1024, number of words
WAIT_STATES, 1, extra cycles between request acceptance and ack (0..15)

Ports:
clk  input  1  single clock, all state on posedge
rst_n  input  1  asynchronous, active-low reset
req  input  1  request valid; sampled only when ready=1
wr_en  input  1  1=write, 0=read; qualified by req
addr  input  ADDRESS_BITS  word index
be  input  WORD_SIZE/8  byte enables for writes; be[i] covers bits 8i+7:8i
data_in  input  WORD_SIZE  write data
ready  output  1  controller can accept a request this cycle
ack  output  1  one-cycle pulse: access complete, data_out/addr_err valid
data_out  output  WORD_SIZE  read data; holds until next ack
addr_err  output  1  addr >= MEMORY on the acked access; valid with ack
busy  output  1  high during post-reset clear sweep

Behaviour:
- Clock/reset (decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: ready=0, ack=0, data_out=0, addr_err=0, busy=1, FSM=INIT, sweep counter=0.
- FSM states: INIT, IDLE, WAIT, RESP.
- INIT: writes 0 to mem[cnt] each cycle, cnt increments 0..MEMORY-1. Takes exactly MEMORY cycles after rst_n deasserts, then goes to IDLE. busy=1, ready=0 throughout.
- IDLE: ready=1, busy=0.
  - On req=1: capture wr_en/addr/be/data_in in this cycle (T) and set ready=0.
  - Go to WAIT if WAIT_STATES>0, else RESP.
  - req=0: stay.
- WAIT: down-counter loaded with WAIT_STATES-1 at acceptance; moves to RESP when it reaches 0; ready=0.
- RESP: performs the access using captured values; ack=1 for exactly one cycle; returns to IDLE with ready=1 next cycle.
- Latency: ack asserted in cycle T+1+WAIT_STATES. Minimum request-to-request spacing is WAIT_STATES+2 cycles.
- Write: for each i with be[i]=1, mem[addr] byte i <= data_in byte i; other bytes unchanged. be=0 is a legal no-op write that is still acked. data_out is unchanged on writes.
- Read: data_out <= mem[addr] registered at the ack edge, i.e. valid while ack=1. be is ignored.
- Out of range (captured addr >= MEMORY): no array access; ack=1 with addr_err=1; data_out <= 0 on reads; writes are dropped. addr_err=0 on every in-range ack.
- Inputs changing after acceptance have no effect; captured values are used.
- req high while ready=0 is ignored (not queued). The master must hold req until it sees ready.
- Reset mid-operation: pending access is abandoned, no ack; any write in WAIT is not performed. Outputs take reset values asynchronously and the INIT sweep restarts from word 0.
- Counters sized with $clog2(MEMORY) and 4 bits for wait; no wrap beyond MEMORY-1.

Optional Feature:
DMEM_STATS_EN:
- Defined: adds outputs rd_count[15:0] and wr_count[15:0], reset to 0. Each increments on an acked in-range read or write respectively, saturating at 16'hFFFF. Erroring accesses are not counted. Not cleared by the INIT sweep, only by rst_n.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- MEMORY=16, WAIT_STATES=1: release rst_n -> busy=1/ready=0 for 16 cycles, then ready=1; reads of addrs 0..15 all return 0.
- Write addr 5, data_in=32'hDEADBEEF, be=4'hF, then write addr 5, data_in=32'h00001234, be=4'b0011, then read addr 5 -> data_out=32'hDEAD1234, addr_err=0.
- WAIT_STATES=3: req accepted at cycle 10 -> ack only at cycle 14. ready=0 cycles 11-14, ready=1 at cycle 15; changing addr during cycles 11-13 does not alter the result.
- Read addr 16 with MEMORY=16 -> ack with addr_err=1, data_out=0; a write to addr 20 leaves all 16 words unchanged.
- Assert rst_n=0 during WAIT of a write to addr 2 with data 32'h55 -> no ack; after the sweep, a read of addr 2 returns 0.
- DMEM_STATS_EN: 3 writes, 2 reads, 1 out-of-range read -> wr_count=3, rd_count=2.
